// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - wide adder sequencer driving one narrow external adder slice
module adder_seq_ctrl #(
    parameter int SLICE_W    = 2,
    parameter int NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] in_lhs,
    input  logic [SLICE_W*NUM_SLICES-1:0] in_rhs,
    input  logic                          in_cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] out_sum,
    output logic                          out_cout,
    output logic                          slice_en,
    output logic [SLICE_W-1:0]            slice_lhs,
    output logic [SLICE_W-1:0]            slice_rhs,
    output logic                          slice_cin,
    input  logic [SLICE_W-1:0]            slice_sum,
    input  logic                          slice_cout,
    output logic                          busy
);

    localparam int TW    = SLICE_W * NUM_SLICES;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [TW-1:0]      lhs_reg;
    logic [TW-1:0]      rhs_reg;
    logic [TW-1:0]      result;
    logic               last_slice;

    assign last_slice = (idx == IDX_W'(NUM_SLICES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            lhs_reg <= '0;
            rhs_reg <= '0;
            result  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lhs_reg <= in_lhs;
                        rhs_reg <= in_rhs;
                        carry   <= in_cin;
                        idx     <= '0;
                        result  <= '0;
                    end
                end
                RUN: begin
                    result[idx*SLICE_W +: SLICE_W] <= slice_sum;
                    carry                          <= slice_cout;
                    if (!last_slice) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slice inputs are forced to zero outside RUN so the external adder sees a quiet bus.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_sum    = '0;
        out_cout   = 1'b0;
        slice_en   = 1'b0;
        slice_lhs  = '0;
        slice_rhs  = '0;
        slice_cin  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                slice_en  = 1'b1;
                slice_lhs = lhs_reg[idx*SLICE_W +: SLICE_W];
                slice_rhs = rhs_reg[idx*SLICE_W +: SLICE_W];
                slice_cin = carry;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = result;
                out_cout  = carry;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - self-checking bench for adder_seq_ctrl
module tb_adder_seq_ctrl;

    localparam int SW = 2;
    localparam int NS = 4;
    localparam int TW = SW * NS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_lhs = '0;
    logic [TW-1:0] in_rhs = '0;
    logic          in_cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [TW-1:0] out_sum;
    logic          out_cout;
    logic          slice_en;
    logic [SW-1:0] slice_lhs;
    logic [SW-1:0] slice_rhs;
    logic          slice_cin;
    logic [SW-1:0] slice_sum;
    logic          slice_cout;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural model of the external adder slice.
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, slice_lhs} + {1'b0, slice_rhs} + {{SW{1'b0}}, slice_cin};
    end

    adder_seq_ctrl #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lhs(in_lhs), .in_rhs(in_rhs), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .slice_en(slice_en), .slice_lhs(slice_lhs), .slice_rhs(slice_rhs),
        .slice_cin(slice_cin), .slice_sum(slice_sum), .slice_cout(slice_cout),
        .busy(busy)
    );

    function automatic int ref_total(int a, int b, int c);
        return a + b + c;
    endfunction

    // Carry entering slice i is bit i*SW of the sum of the low i*SW bits of each operand.
    function automatic int ref_slice_cin(int a, int b, int c, int i);
        int m;
        m = 1 << (i * SW);
        return ((a % m) + (b % m) + c) / m;
    endfunction

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 ||
            slice_en !== 1'b0 || slice_lhs !== '0 || slice_rhs !== '0 || slice_cin !== 1'b0 ||
            busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: rdy=%b vld=%b sum=%h cout=%b en=%b sl=%h sr=%h sc=%b busy=%b, required 1 0 00 0 0 0 0 0 0",
                     tag, in_ready, out_valid, out_sum, out_cout, slice_en, slice_lhs, slice_rhs, slice_cin, busy);
        end
    endtask

    // Runs one operation: checks RUN-phase trace and latency, returns with DONE observed.
    task automatic run_op(input int a, input int b, input int c, input bit scramble,
                          output int lat);
        int i;
        @(negedge clk);
        in_lhs = TW'(a); in_rhs = TW'(b); in_cin = c[0]; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat <= 20) begin
            i = lat - 1;
            checks++;
            if (i >= NS || busy !== 1'b1 || in_ready !== 1'b0 || slice_en !== 1'b1 ||
                out_sum !== '0 ||
                int'(slice_lhs) != ((a >> (i * SW)) % (1 << SW)) ||
                int'(slice_rhs) != ((b >> (i * SW)) % (1 << SW)) ||
                int'(slice_cin) != ref_slice_cin(a, b, c, i)) begin
                failures++;
                $display("FAIL run_trace step %0d: en=%b lhs=%0d rhs=%0d cin=%b busy=%b rdy=%b, required lhs=%0d rhs=%0d cin=%0d",
                         i, slice_en, slice_lhs, slice_rhs, slice_cin, busy, in_ready,
                         (a >> (i * SW)) % (1 << SW), (b >> (i * SW)) % (1 << SW), ref_slice_cin(a, b, c, i));
            end
            if (scramble) begin
                in_lhs = TW'($urandom); in_rhs = TW'($urandom); in_cin = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != NS + 1) begin
            failures++;
            $display("FAIL latency: got %0d cycles, required %0d", lat, NS + 1);
        end
        checks++;
        if ({out_cout, out_sum} !== (TW+1)'(ref_total(a, b, c)) || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL result %h+%h+%0d: got cout=%b sum=%h busy=%b rdy=%b, required %h",
                     a, b, c, out_cout, out_sum, busy, in_ready, (TW+1)'(ref_total(a, b, c)));
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        check_idle_outputs("return_to_idle");
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_basic();
        int lat;
        run_op('h01, 'h03, 1, 1'b0, lat);
        finish_op();
        run_op('hB6, 'h5D, 0, 1'b0, lat);
        finish_op();
    endtask

    task automatic test_wrap();
        int lat;
        run_op('hFF, 'h01, 0, 1'b0, lat); finish_op();
        run_op('hFF, 'hFF, 1, 1'b0, lat); finish_op();
        run_op('h00, 'h00, 0, 1'b0, lat); finish_op();
    endtask

    task automatic test_random();
        int lat;
        for (int k = 0; k < 20; k++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)), 1'b0, lat);
            finish_op();
        end
    endtask

    task automatic test_operand_change();
        int lat;
        for (int k = 0; k < 4; k++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)), 1'b1, lat);
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [TW-1:0] held_sum;
        logic          held_cout;
        out_ready = 1'b0;
        run_op('h9C, 'h7A, 1, 1'b0, lat);
        held_sum = out_sum; held_cout = out_cout;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k == 2);
            in_lhs = 8'h11; in_rhs = 8'h22; in_cin = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sum !== held_sum || out_cout !== held_cout || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure hold %0d: vld=%b sum=%h cout=%b rdy=%b, required 1 %h %b 0",
                         k, out_valid, out_sum, out_cout, in_ready, held_sum, held_cout);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        finish_op();
        run_op('h44, 'h55, 0, 1'b0, lat);
        finish_op();
    endtask

    task automatic test_async_reset();
        int lat;
        @(negedge clk);
        in_lhs = 8'hE7; in_rhs = 8'hC3; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (slice_en !== 1'b1 || slice_lhs !== 2'(8'hE7 >> 4)) begin
            failures++;
            $display("FAIL abort_setup: en=%b lhs=%0d, required 1 %0d", slice_en, slice_lhs, 2'(8'hE7 >> 4));
        end
        #1 reset_n = 1'b0;
        #1 check_idle_outputs("async_reset_immediate");
        @(negedge clk);
        reset_n = 1'b1;
        check_idle_outputs("after_abort");
        run_op('h10, 'h20, 0, 1'b0, lat);
        finish_op();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_operand_change();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
